// File: rtl/mpdmac_job_sched.sv
// Round-robin job scheduler in front of the MPDMAC engine: grants one matrix-copy
// job at a time, starts the engine, watches its done level and returns a tagged completion.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for engine idle and a pending request; arbitrates
// START       | one-cycle engine start pulse with job registers on the bus
// WAIT_BUSY   | waiting for done_i to fall; bounded by BUSY_TIMEOUT
// WAIT_DONE   | engine running; waiting for done_i to rise (unbounded)
// CMPL        | one-cycle tagged completion pulse to the requester
module mpdmac_job_sched #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*32-1:0]   req_src_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_dst_addr_i,
    input  logic [NUM_REQ*6-1:0]    req_mat_width_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [31:0]             src_addr_o,
    output logic [31:0]             dst_addr_o,
    output logic [5:0]              mat_width_o,
    output logic                    start_o,
    input  logic                    done_i,
    output logic                    cmpl_valid_o,
    output logic [ID_W-1:0]         cmpl_id_o,
    output logic                    cmpl_err_o,
    output logic                    busy_o
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CMPL
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic               err_q;
    logic [31:0]        src_q, dst_q;
    logic [5:0]         width_q;
    logic [CNT_W-1:0]   tmo_cnt_q;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    cand;
    logic [5:0]         gnt_width;
    logic               accept;
    logic               timeout;

    // First valid requester at or after rr_ptr, with wrap-around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_width = req_mat_width_i[6*gnt_idx +: 6];
    assign accept    = (state_q == S_IDLE) && done_i && gnt_found;
    assign timeout   = (state_q == S_WAIT_BUSY) && done_i && (tmo_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = '0;
        start_o      = 1'b0;
        cmpl_valid_o = 1'b0;
        cmpl_err_o   = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    state_d = (gnt_width == '0) ? S_CMPL : S_START;
                end
            end
            S_START: begin
                start_o = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!done_i)      state_d = S_WAIT_DONE;
                else if (timeout) state_d = S_CMPL;
            end
            S_WAIT_DONE: begin
                if (done_i) state_d = S_CMPL;
            end
            S_CMPL: begin
                cmpl_valid_o = 1'b1;
                cmpl_err_o   = err_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job registers, round-robin pointer and the busy-edge timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            width_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (accept) begin
                src_q    <= req_src_addr_i[32*gnt_idx +: 32];
                dst_q    <= req_dst_addr_i[32*gnt_idx +: 32];
                width_q  <= gnt_width;
                id_q     <= gnt_idx;
                err_q    <= (gnt_width == '0);
                rr_ptr_q <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            end
            if (state_q == S_START)
                tmo_cnt_q <= CNT_W'(BUSY_TIMEOUT - 1);
            else if (state_q == S_WAIT_BUSY && tmo_cnt_q != '0)
                tmo_cnt_q <= tmo_cnt_q - CNT_W'(1);
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign src_addr_o  = src_q;
    assign dst_addr_o  = dst_q;
    assign mat_width_o = width_q;
    assign cmpl_id_o   = id_q;

endmodule

// File: tb/tb_mpdmac_job_sched.sv
// Self-checking bench for mpdmac_job_sched: directed scenarios plus randomized jobs
// checked against a transaction-level model of grant order and completion latency.
module tb_mpdmac_job_sched;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int BUSY_TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] src_bus, dst_bus;
    logic [NUM_REQ*6-1:0]  wid_bus;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           src_addr, dst_addr;
    logic [5:0]            mat_width;
    logic                  start, done_i, cmpl_valid, cmpl_err, busy;
    logic [ID_W-1:0]       cmpl_id;

    logic [31:0] src_a [NUM_REQ];
    logic [31:0] dst_a [NUM_REQ];
    logic [5:0]  wid_a [NUM_REQ];

    int n_err = 0;
    int n_chk = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign src_bus[32*i +: 32] = src_a[i];
        assign dst_bus[32*i +: 32] = dst_a[i];
        assign wid_bus[6*i +: 6]   = wid_a[i];
    end

    mpdmac_job_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_src_addr_i(src_bus), .req_dst_addr_i(dst_bus),
        .req_mat_width_i(wid_bus), .req_ready_o(req_ready),
        .src_addr_o(src_addr), .dst_addr_o(dst_addr), .mat_width_o(mat_width),
        .start_o(start), .done_i(done_i),
        .cmpl_valid_o(cmpl_valid), .cmpl_id_o(cmpl_id), .cmpl_err_o(cmpl_err),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job: optional engine-busy wait before the grant, then engine low for lat cycles or stuck.
    task automatic do_job(input logic [NUM_REQ-1:0] mask, input int pre, input int lat,
                          input bit stuck, output int g);
        int exp_c, c;
        logic [NUM_REQ-1:0] one;
        req_valid = mask;
        done_i    = (pre > 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < pre; i++) begin
            #1;
            chk("ready_engine_busy", req_ready, 0);
            step();
        end
        done_i = 1'b1;
        #1;
        g = pick(mask, ptr_m);
        one = '0;
        one[g] = 1'b1;
        chk("grant", req_ready, one);
        chk("busy_accept", busy, 0);
        step();
        ptr_m = (g + 1) % NUM_REQ;
        if (wid_a[g] == 0) begin
            chk("zw_cmpl", cmpl_valid, 1);
            chk("zw_id", cmpl_id, g);
            chk("zw_err", cmpl_err, 1);
            chk("zw_start", start, 0);
            step();
            return;
        end
        chk("start", start, 1);
        chk("src", src_addr, src_a[g]);
        chk("dst", dst_addr, dst_a[g]);
        chk("width", mat_width, wid_a[g]);
        chk("start_ready", req_ready, 0);
        chk("start_busy", busy, 1);
        step();
        exp_c = stuck ? BUSY_TIMEOUT + 1 : lat + 2;
        c = 0;
        for (int k = 1; k <= 60; k++) begin
            done_i = (!stuck && k <= lat) ? 1'b0 : 1'b1;
            #1;
            if (cmpl_valid) begin
                c = k;
                break;
            end
            chk("wait_quiet", {start, req_ready}, 0);
            step();
        end
        chk("latency", c, exp_c);
        chk("cmpl_id", cmpl_id, g);
        chk("cmpl_err", cmpl_err, stuck);
        chk("cmpl_no_start", start, 0);
        chk("hold_src", src_addr, src_a[g]);
        step();
        done_i = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_a[i] = $urandom;
            dst_a[i] = $urandom;
            wid_a[i] = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int exp_rr [8];
        exp_rr = '{0, 1, 2, 3, 0, 1, 3, 1};
        rst = 1'b1;
        req_valid = '0;
        done_i = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_a[i] = 32'h100 * (i + 1);
            dst_a[i] = 32'h8000 + i;
            wid_a[i] = 6'(i + 4);
        end
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_outputs", {req_ready, src_addr, dst_addr, mat_width, start, cmpl_valid,
                            cmpl_id, cmpl_err, busy}, 0);
        step();

        for (int j = 0; j < 8; j++) begin
            do_job((j < 5) ? 4'hF : 4'b1010, 0, 3, 1'b0, g);
            chk("rr_order", g, exp_rr[j]);
        end

        src_a[2] = 32'h1000; dst_a[2] = 32'h2000; wid_a[2] = 6'd8;
        do_job(4'b0100, 0, 20, 1'b0, g);
        chk("single_id", g, 2);

        wid_a[1] = 6'd0;
        do_job(4'b0010, 0, 1, 1'b0, g);
        chk("zw_grant", g, 1);
        wid_a[1] = 6'd5;

        do_job(4'b0001, 0, 0, 1'b1, g);
        do_job(4'b0001, 0, 1, 1'b0, g);
        do_job(4'b1000, 3, 5, 1'b0, g);
        chk("done_low_grant", g, 3);

        req_valid = 4'b0100;
        done_i = 1'b1;
        step();
        step();
        done_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        #1;
        chk("midjob_rst", {req_ready, src_addr, dst_addr, mat_width, start, cmpl_valid,
                           cmpl_id, cmpl_err, busy}, 0);
        ptr_m = 0;
        done_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_cmpl_after_rst", {cmpl_valid, busy}, 0);
        end
        do_job(4'hF, 0, 2, 1'b0, g);
        chk("rr_after_rst", g, 0);

        for (int j = 0; j < 40; j++) begin
            rand_data();
            do_job(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(1, 20),
                   1'($urandom_range(0, 7) == 0), g);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
